wb_commit_checker: RTL and testbench
====================================

Name: wb_commit_checker

Overview:
- Synthesizable self-check block downstream of the single-cycle CPU's register writeback port; it taps reg_write/rd/write_data.
- Holds a table of expected (rd, data) commits that a bench or boot loader writes in.
- Compares live writebacks against that table in order and raises sticky pass/fail with error capture and a hang timeout.
- Replaces manual end-of-simulation register dumps with a cycle-accurate verdict.

Parameters:
- DEPTH, 16, number of expected-commit entries (power of two).
- AW, 4, log2(DEPTH).
- TIMEOUT, 1024, max cycles in RUN without an accepted commit before FAIL.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (rst=0 resets on clk edge).
- clear  input  1  empty the table and return to IDLE.
- load_en  input  1  append one expected entry (IDLE only).
- load_rd  input  5  expected destination register.
- load_data  input  32  expected write data.
- start  input  1  begin checking (IDLE/PASS/FAIL).
- wb_en  input  1  CPU reg_write.
- wb_rd  input  5  CPU rd.
- wb_data  input  32  CPU write_data.
- busy  output  1  state==RUN.
- pass  output  1  sticky pass.
- fail  output  1  sticky fail.
- timeout  output  1  fail was caused by timeout.
- overflow  output  1  a load was attempted with the table full.
- exp_len  output  AW+1  number of loaded entries (0..DEPTH).
- match_cnt  output  AW+1  commits matched in the current run.
- err_idx  output  AW  table index at first failure.
- err_rd  output  5  offending wb_rd (0 on timeout).
- err_data  output  32  offending wb_data (0 on timeout).

Behaviour:
- All outputs are registered. On rst=0 every output is 0, state is IDLE, and load_ptr, cmp_ptr and the timer are 0. Table contents are don't-care after reset.
- States: IDLE, RUN, PASS, FAIL.
- Priority within a cycle: rst > clear > start > load_en > wb event > timeout.
- clear (any state):
  - next state IDLE;
  - exp_len, match_cnt, overflow, pass, fail, timeout and the err_* outputs are set to 0.
- IDLE, load_en=1, start=0:
  - if exp_len<DEPTH, write entry[exp_len]={load_rd,load_data} and increment exp_len;
  - else leave the table unchanged and set overflow=1.
  - load_en is ignored in all other states and whenever start=1 in the same cycle.
- start in IDLE/PASS/FAIL:
  - next state RUN; cmp_ptr, match_cnt, timer, pass, fail, timeout and err_* are set to 0.
  - The table and exp_len are retained, so a re-run checks the same table.
  - If exp_len==0, go to PASS instead of RUN (pass=1 the next cycle).
  - start is ignored in RUN.
- RUN, commit accepted (wb_en=1 and wb_rd!=0):
  - Writes to x0 are ignored and do not reset the timer.
  - Compare {wb_rd,wb_data} against entry[cmp_ptr] with exact 37-bit equality.
  - Match: cmp_ptr++, match_cnt++, timer=0. If cmp_ptr was exp_len-1, the next state is PASS and pass=1 one cycle after the last matching commit.
  - Mismatch: next state FAIL, fail=1; err_idx=cmp_ptr, err_rd=wb_rd, err_data=wb_data; match_cnt is frozen.
- RUN timer:
  - Increments each cycle with no accepted commit.
  - When it reaches TIMEOUT-1 with no commit that cycle: FAIL, fail=timeout=1, err_idx=cmp_ptr, err_rd=0, err_data=0.
  - A commit in that same cycle wins, so no timeout is raised.
- PASS/FAIL:
  - Sticky until start, clear or reset.
  - Further wb events are ignored; surplus commits after PASS do not flip the verdict.
- Reset mid-RUN aborts the check. The table must be reloaded because exp_len=0.
- Counters saturate at their widths:
  - exp_len never exceeds DEPTH;
  - cmp_ptr never exceeds exp_len-1 while in RUN.
- Single-cycle CPU timing: one commit can arrive every cycle. The checker must sustain back-to-back matches with no stall.

Test Plan:
- Load 3 entries (x3,7), (x4,0xFFFFFFFD), (x5,7); start; drive those three commits on consecutive cycles -> busy for 3 cycles, then pass=1, match_cnt=3, fail=0.
- Same table; second commit driven as (x4,0x00000003) -> fail=1, err_idx=1, err_rd=4, err_data=0x3, match_cnt=1, timeout=0.
- Commits interleaved with wb_en=1, wb_rd=0 writes of 0xDEADBEEF, plus wb_en=0 idle cycles -> x0 writes and idle cycles ignored, pass=1, match_cnt=3.
- TIMEOUT=8, one entry loaded, start, no commits -> fail=1 and timeout=1 exactly 8 cycles after entering RUN; err_idx=0, err_rd=0.
- Load 17 entries with DEPTH=16 -> exp_len=16, overflow=1. Then start with exp_len=0 after clear -> pass=1 one cycle after start.
- Assert rst=0 mid-RUN after 1 match, then release and load/start again -> all outputs 0 during reset; the fresh run passes independently. Assert clear and start together -> IDLE, exp_len=0.

Source files
------------

// File: rtl/wb_commit_checker.sv
// Checks live register writebacks against a preloaded table of expected (rd, data) commits, in order.
// One commit is compared per cycle with no stall; the verdict is registered and follows the deciding edge.
module wb_commit_checker #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          load_en,
   input  logic [4:0]    load_rd,
   input  logic [31:0]   load_data,
   input  logic          start,
   input  logic          wb_en,
   input  logic [4:0]    wb_rd,
   input  logic [31:0]   wb_data,
   output logic          busy,
   output logic          pass,
   output logic          fail,
   output logic          timeout,
   output logic          overflow,
   output logic [AW:0]   exp_len,
   output logic [AW:0]   match_cnt,
   output logic [AW-1:0] err_idx,
   output logic [4:0]    err_rd,
   output logic [31:0]   err_data
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

   state_t        state, state_nxt;
   logic [36:0]   tbl [DEPTH];
   logic [AW-1:0] cmp_ptr;
   logic [TW-1:0] timer;
   logic          accept, hit, last, full;
   logic          do_start, do_load, do_match, do_miss, do_tmo;

   // Writes to x0 never count as commits.
   assign accept = wb_en && (wb_rd != 5'd0);
   assign hit    = ({wb_rd, wb_data} == tbl[cmp_ptr]);
   assign last   = ({1'b0, cmp_ptr} == exp_len - (AW+1)'(1));
   assign full   = (exp_len == (AW+1)'(DEPTH));

   always_comb begin
      state_nxt = state;
      do_start  = 1'b0;
      do_load   = 1'b0;
      do_match  = 1'b0;
      do_miss   = 1'b0;
      do_tmo    = 1'b0;
      if (clear) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_RUN: begin
               if (accept) begin
                  if (hit) begin
                     do_match = 1'b1;
                     if (last) state_nxt = S_PASS;
                  end else begin
                     do_miss   = 1'b1;
                     state_nxt = S_FAIL;
                  end
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  do_tmo    = 1'b1;
                  state_nxt = S_FAIL;
               end
            end
            default: begin
               if (start) begin
                  do_start  = 1'b1;
                  state_nxt = (exp_len == '0) ? S_PASS : S_RUN;
               end else if (load_en && (state == S_IDLE)) begin
                  do_load = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
         overflow  <= 1'b0;
         exp_len   <= '0;
         match_cnt <= '0;
         cmp_ptr   <= '0;
         timer     <= '0;
         err_idx   <= '0;
         err_rd    <= '0;
         err_data  <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == S_RUN);
         pass  <= (state_nxt == S_PASS);
         fail  <= (state_nxt == S_FAIL);
         if (clear) begin
            exp_len   <= '0;
            match_cnt <= '0;
            overflow  <= 1'b0;
            timeout   <= 1'b0;
            cmp_ptr   <= '0;
            timer     <= '0;
            err_idx   <= '0;
            err_rd    <= '0;
            err_data  <= '0;
         end else if (do_start) begin
            cmp_ptr   <= '0;
            match_cnt <= '0;
            timer     <= '0;
            timeout   <= 1'b0;
            err_idx   <= '0;
            err_rd    <= '0;
            err_data  <= '0;
         end else if (do_load) begin
            if (full) overflow <= 1'b1;
            else      exp_len  <= exp_len + (AW+1)'(1);
         end else if (do_match) begin
            // The pointer parks on the last entry so it never runs past the table.
            if (!last) cmp_ptr <= cmp_ptr + AW'(1);
            match_cnt <= match_cnt + (AW+1)'(1);
            timer     <= '0;
         end else if (do_miss) begin
            err_idx  <= cmp_ptr;
            err_rd   <= wb_rd;
            err_data <= wb_data;
         end else if (do_tmo) begin
            timeout  <= 1'b1;
            err_idx  <= cmp_ptr;
            err_rd   <= '0;
            err_data <= '0;
         end else if (state == S_RUN) begin
            timer <= timer + TW'(1);
         end
      end
   end

   // Table storage needs no reset; exp_len alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (rst && do_load && !full) tbl[exp_len[AW-1:0]] <= {load_rd, load_data};
   end

endmodule

// File: tb/tb_wb_commit_checker.sv
// Bench for wb_commit_checker: directed vector table, hand-written corner sequences, and random stimulus against a queue-based model.
module tb_wb_commit_checker;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int TO    = 8;
   localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0, clear = 1'b0, load_en = 1'b0, start = 1'b0, wb_en = 1'b0;
   logic [4:0]  load_rd = '0, wb_rd = '0;
   logic [31:0] load_data = '0, wb_data = '0;
   logic        busy, pass, fail, timeout, overflow;
   logic [AW:0] exp_len, match_cnt;
   logic [AW-1:0] err_idx;
   logic [4:0]  err_rd;
   logic [31:0] err_data;

   wb_commit_checker #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .clear(clear), .load_en(load_en), .load_rd(load_rd),
      .load_data(load_data), .start(start), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .busy(busy), .pass(pass), .fail(fail), .timeout(timeout), .overflow(overflow),
      .exp_len(exp_len), .match_cnt(match_cnt), .err_idx(err_idx), .err_rd(err_rd),
      .err_data(err_data)
   );

   typedef struct packed {
      logic busy, pass, fail, timeout, overflow;
      logic [4:0] exp_len, match_cnt;
      logic [3:0] err_idx;
      logic [4:0] err_rd;
      logic [31:0] err_data;
   } outs_t;

   outs_t act;
   assign act = {busy, pass, fail, timeout, overflow, exp_len, match_cnt, err_idx, err_rd, err_data};

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   function automatic outs_t eo(input logic bz, input logic ps, input logic fl, input logic tm,
                                input logic ov, input int el, input int mc, input int ei,
                                input int er, input logic [31:0] ed);
      outs_t o;
      o.busy = bz; o.pass = ps; o.fail = fl; o.timeout = tm; o.overflow = ov;
      o.exp_len = 5'(el); o.match_cnt = 5'(mc); o.err_idx = 4'(ei); o.err_rd = 5'(er);
      o.err_data = ed;
      return o;
   endfunction

   // Reference model: expected commits live in a queue, progress is an index into it.
   logic [36:0] m_tbl[$];
   int          m_mode = M_IDLE, m_ptr = 0, m_idle = 0;
   logic        m_to = 1'b0, m_ovf = 1'b0;
   logic [3:0]  m_eidx = '0;
   logic [4:0]  m_erd = '0;
   logic [31:0] m_edat = '0;

   task automatic m_zero();
      m_tbl.delete();
      m_mode = M_IDLE; m_ptr = 0; m_idle = 0; m_to = 1'b0; m_ovf = 1'b0;
      m_eidx = '0; m_erd = '0; m_edat = '0;
   endtask

   task automatic model_step();
      if (!rst || clear) begin
         m_zero();
      end else if (start && m_mode != M_RUN) begin
         m_ptr = 0; m_idle = 0; m_to = 1'b0; m_eidx = '0; m_erd = '0; m_edat = '0;
         m_mode = (m_tbl.size() == 0) ? M_PASS : M_RUN;
      end else if (m_mode == M_IDLE && load_en) begin
         if (m_tbl.size() < DEPTH) m_tbl.push_back({load_rd, load_data});
         else m_ovf = 1'b1;
      end else if (m_mode == M_RUN) begin
         if (wb_en && wb_rd != 5'd0) begin
            if ({wb_rd, wb_data} == m_tbl[m_ptr]) begin
               m_ptr++;
               m_idle = 0;
               if (m_ptr == m_tbl.size()) m_mode = M_PASS;
            end else begin
               m_mode = M_FAIL; m_eidx = 4'(m_ptr); m_erd = wb_rd; m_edat = wb_data;
            end
         end else if (m_idle == TO - 1) begin
            m_mode = M_FAIL; m_to = 1'b1; m_eidx = 4'(m_ptr);
         end else begin
            m_idle++;
         end
      end
   endtask

   function automatic outs_t m_out();
      outs_t o;
      o.busy = (m_mode == M_RUN); o.pass = (m_mode == M_PASS); o.fail = (m_mode == M_FAIL);
      o.timeout = m_to; o.overflow = m_ovf;
      o.exp_len = 5'(m_tbl.size()); o.match_cnt = 5'(m_ptr);
      o.err_idx = m_eidx; o.err_rd = m_erd; o.err_data = m_edat;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_in();
      clear = 1'b0; start = 1'b0; load_en = 1'b0; wb_en = 1'b0;
      load_rd = '0; load_data = '0; wb_rd = '0; wb_data = '0;
   endtask

   task automatic ld(input logic [4:0] r, input logic [31:0] d);
      idle_in(); load_en = 1'b1; load_rd = r; load_data = d;
   endtask

   task automatic wb(input logic [4:0] r, input logic [31:0] d);
      idle_in(); wb_en = 1'b1; wb_rd = r; wb_data = d;
   endtask

   typedef struct {
      string nm;
      logic clr, st, ld;
      logic [4:0] lrd;
      logic [31:0] ldat;
      logic we;
      logic [4:0] wrd;
      logic [31:0] wdat;
      outs_t e;
   } vec_t;

   vec_t vt[$];

   task automatic add(input string nm, input logic c, input logic s, input logic l,
                      input logic [4:0] lr, input logic [31:0] ldt, input logic w,
                      input logic [4:0] wr, input logic [31:0] wd, input outs_t e);
      vec_t v;
      v.nm = nm; v.clr = c; v.st = s; v.ld = l; v.lrd = lr; v.ldat = ldt;
      v.we = w; v.wrd = wr; v.wdat = wd; v.e = e;
      vt.push_back(v);
   endtask

   initial begin
      // Directed table: pass, mismatch, x0/idle interleave, clear+start, empty-table start.
      add("ld0",    0,0,1, 3, 32'd7,        0,0,0,             eo(0,0,0,0,0,1,0,0,0,0));
      add("ld1",    0,0,1, 4, 32'hFFFFFFFD, 0,0,0,             eo(0,0,0,0,0,2,0,0,0,0));
      add("ld2",    0,0,1, 5, 32'd7,        0,0,0,             eo(0,0,0,0,0,3,0,0,0,0));
      add("st1",    0,1,0, 0, 0,            0,0,0,             eo(1,0,0,0,0,3,0,0,0,0));
      add("c1a",    0,0,0, 0, 0,            1,3,32'd7,         eo(1,0,0,0,0,3,1,0,0,0));
      add("c1b",    0,0,0, 0, 0,            1,4,32'hFFFFFFFD,  eo(1,0,0,0,0,3,2,0,0,0));
      add("c1c",    0,0,0, 0, 0,            1,5,32'd7,         eo(0,1,0,0,0,3,3,0,0,0));
      add("surplus",0,0,0, 0, 0,            1,6,32'd1,         eo(0,1,0,0,0,3,3,0,0,0));
      add("st2",    0,1,0, 0, 0,            0,0,0,             eo(1,0,0,0,0,3,0,0,0,0));
      add("c2a",    0,0,0, 0, 0,            1,3,32'd7,         eo(1,0,0,0,0,3,1,0,0,0));
      add("c2bad",  0,0,0, 0, 0,            1,4,32'd3,         eo(0,0,1,0,0,3,1,1,4,32'd3));
      add("c2after",0,0,0, 0, 0,            1,5,32'd7,         eo(0,0,1,0,0,3,1,1,4,32'd3));
      add("st3",    0,1,0, 0, 0,            0,0,0,             eo(1,0,0,0,0,3,0,0,0,0));
      add("x0a",    0,0,0, 0, 0,            1,0,32'hDEADBEEF,  eo(1,0,0,0,0,3,0,0,0,0));
      add("gap",    0,0,0, 0, 0,            0,0,0,             eo(1,0,0,0,0,3,0,0,0,0));
      add("c3a",    0,0,0, 0, 0,            1,3,32'd7,         eo(1,0,0,0,0,3,1,0,0,0));
      add("x0b",    0,0,0, 0, 0,            1,0,32'hDEADBEEF,  eo(1,0,0,0,0,3,1,0,0,0));
      add("c3b",    0,0,0, 0, 0,            1,4,32'hFFFFFFFD,  eo(1,0,0,0,0,3,2,0,0,0));
      add("gap2",   0,0,0, 0, 0,            0,0,0,             eo(1,0,0,0,0,3,2,0,0,0));
      add("c3c",    0,0,0, 0, 0,            1,5,32'd7,         eo(0,1,0,0,0,3,3,0,0,0));
      add("clrst",  1,1,0, 0, 0,            0,0,0,             eo(0,0,0,0,0,0,0,0,0,0));
      add("stld",   0,1,1, 9, 32'd9,        0,0,0,             eo(0,1,0,0,0,0,0,0,0,0));
      add("ldpass", 0,0,1, 9, 32'd9,        0,0,0,             eo(0,1,0,0,0,0,0,0,0,0));
      add("clr",    1,0,0, 0, 0,            0,0,0,             eo(0,0,0,0,0,0,0,0,0,0));

      idle_in();
      rst = 1'b0;
      tick(); tick();
      chk("reset", 64'(act), 64'(outs_t'(0)));
      rst = 1'b1;

      foreach (vt[i]) begin
         idle_in();
         clear = vt[i].clr; start = vt[i].st; load_en = vt[i].ld;
         load_rd = vt[i].lrd; load_data = vt[i].ldat;
         wb_en = vt[i].we; wb_rd = vt[i].wrd; wb_data = vt[i].wdat;
         tick();
         chk(vt[i].nm, 64'(act), 64'(vt[i].e));
      end

      // Timeout fires exactly TO cycles after entering RUN.
      ld(5'd9, 32'h55); tick();
      idle_in(); start = 1'b1; tick();
      chk("to_busy", 64'(act), 64'(eo(1,0,0,0,0,1,0,0,0,0)));
      idle_in();
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (k == TO - 1) chk("to_pre", 64'({busy, fail}), 64'(2'b10));
      end
      chk("to_hit", 64'(act), 64'(eo(0,0,1,1,0,1,0,0,0,0)));

      // A commit on the last timer cycle wins over the timeout.
      idle_in(); clear = 1'b1; tick();
      ld(5'd9, 32'h55); tick();
      ld(5'd10, 32'h66); tick();
      idle_in(); start = 1'b1; tick();
      idle_in();
      for (int k = 0; k < TO - 1; k++) tick();
      wb(5'd9, 32'h55); tick();
      chk("to_race", 64'(act), 64'(eo(1,0,0,0,0,2,1,0,0,0)));
      wb(5'd10, 32'h66); tick();
      chk("to_race_pass", 64'(act), 64'(eo(0,1,0,0,0,2,2,0,0,0)));

      // Overflow on the 17th load, then start on an empty table.
      idle_in(); clear = 1'b1; tick();
      for (int i = 0; i < DEPTH + 1; i++) begin
         ld(5'(i + 1), 32'(i)); tick();
         if (i == DEPTH - 1) chk("full", 64'(act), 64'(eo(0,0,0,0,0,16,0,0,0,0)));
      end
      chk("overflow", 64'(act), 64'(eo(0,0,0,0,1,16,0,0,0,0)));
      idle_in(); clear = 1'b1; tick();
      idle_in(); start = 1'b1; tick();
      chk("empty_pass", 64'(act), 64'(eo(0,1,0,0,0,0,0,0,0,0)));

      // Reset in the middle of a run, then an independent re-run.
      idle_in(); clear = 1'b1; tick();
      ld(5'd7, 32'h11); tick();
      ld(5'd8, 32'h22); tick();
      idle_in(); start = 1'b1; tick();
      wb(5'd7, 32'h11); tick();
      chk("pre_rst", 64'(act), 64'(eo(1,0,0,0,0,2,1,0,0,0)));
      idle_in(); rst = 1'b0; tick();
      chk("mid_rst", 64'(act), 64'(outs_t'(0)));
      rst = 1'b1;
      ld(5'd12, 32'hABC); tick();
      idle_in(); start = 1'b1; tick();
      wb(5'd12, 32'hABC); tick();
      chk("rerun", 64'(act), 64'(eo(0,1,0,0,0,1,1,0,0,0)));

      // Random stimulus against the model.
      idle_in(); rst = 1'b0; tick(); rst = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) != 0);
         clear     = ($urandom_range(0, 39) == 0);
         start     = ($urandom_range(0, 24) == 0);
         load_en   = ($urandom_range(0, 2) == 0);
         load_rd   = 5'($urandom_range(0, 3));
         load_data = 32'($urandom_range(0, 3));
         if (m_mode == M_RUN && $urandom_range(0, 9) < 6) begin
            wb_en = 1'b1;
            {wb_rd, wb_data} = m_tbl[m_ptr];
            if ($urandom_range(0, 19) == 0) wb_data = wb_data ^ 32'd1;
         end else begin
            wb_en   = 1'($urandom_range(0, 1));
            wb_rd   = 5'($urandom_range(0, 3));
            wb_data = 32'($urandom_range(0, 3));
         end
         tick();
         chk("rand", 64'(act), 64'(m_out()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
